bp_dma_word_master: RTL

BP_DMA_WORD_MASTER -- requirements
Module: bp_dma_word_master

---
 rtl/bp_dma_word_master_pkg.sv | 18 +
 rtl/bsg_counter_clear_up.sv | 44 ++++
 rtl/bp_dma_word_master.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/bp_dma_word_master_pkg.sv
// Shared types for the DMA word master: FSM state encoding and a counter sizing helper.
package bp_dma_word_master_pkg;

    typedef enum logic [2:0] {
        e_ready,
        e_rd_pkt,
        e_rd_data,
        e_wr_pkt,
        e_wr_data,
        e_resp
    } bp_dma_word_master_state_e;

    // Index width for n items, never zero so a single-entry case still gets a 1-bit signal.
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear that wraps to zero after max_val_p.
module bsg_counter_clear_up
    import bp_dma_word_master_pkg::*;
#(
    parameter int  max_val_p  = 3,
    parameter int  init_val_p = 0,
    localparam int width_lp   = safe_clog2(max_val_p + 1)
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                clear_i,
    input  logic                up_i,
    output logic [width_lp-1:0] count_o
);

    localparam logic [width_lp-1:0] max_lp  = width_lp'(max_val_p);
    localparam logic [width_lp-1:0] init_lp = width_lp'(init_val_p);

    logic [width_lp-1:0] count_q;
    logic [width_lp-1:0] count_d;

    // Clear wins over up, so a last-beat increment that also restarts the line lands on init.
    // NOTE: combinational blocks assign a default first; every path then has a value and no latch appears.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = init_lp;
        end else if (up_i) begin
            count_d = (count_q == max_lp) ? '0 : count_q + width_lp'(1);
        end
    end

    // NOTE: registers take non-blocking <= so every flop samples pre-edge values; comb logic uses blocking =.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q <= init_lp;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/bp_dma_word_master.sv
// Single-word memory master over a line-granular DMA port: reads fetch the line, writes do line read-modify-write.
module bp_dma_word_master
    import bp_dma_word_master_pkg::*;
#(
    parameter int dma_addr_width_p = 32,
    parameter int dma_data_width_p = 64,
    parameter int dma_burst_len_p  = 4,
    parameter int dma_mask_width_p = 4
) (
    input  logic                                       clk_i,
    input  logic                                       reset_n_i,

    input  logic [dma_addr_width_p-1:0]                req_addr_i,
    input  logic                                       req_write_i,
    input  logic [dma_data_width_p-1:0]                req_data_i,
    input  logic                                       req_v_i,
    output logic                                       req_ready_and_o,

    output logic [dma_data_width_p-1:0]                resp_data_o,
    output logic                                       resp_v_o,
    input  logic                                       resp_ready_and_i,

    output logic [dma_mask_width_p+dma_addr_width_p:0] dma_pkt_o,
    output logic                                       dma_pkt_v_o,
    input  logic                                       dma_pkt_yumi_i,

    input  logic [dma_data_width_p-1:0]                dma_data_i,
    input  logic                                       dma_data_v_i,
    output logic                                       dma_data_ready_and_o,

    output logic [dma_data_width_p-1:0]                dma_data_o,
    output logic                                       dma_data_v_o,
    input  logic                                       dma_data_yumi_i
);

    localparam int word_offset_lp = $clog2(dma_data_width_p / 8);
    localparam int lg_burst_lp    = $clog2(dma_burst_len_p);
    localparam int cnt_width_lp   = safe_clog2(dma_burst_len_p);
    localparam int line_bytes_lp  = dma_burst_len_p * (dma_data_width_p / 8);

    localparam logic [dma_addr_width_p-1:0] line_mask_lp = ~dma_addr_width_p'(line_bytes_lp - 1);
    localparam logic [cnt_width_lp-1:0]     last_beat_lp = cnt_width_lp'(dma_burst_len_p - 1);

    typedef struct packed {
        logic                        write_not_read;
        logic [dma_mask_width_p-1:0] mask;
        logic [dma_addr_width_p-1:0] addr;
    } bsg_cache_dma_pkt_s;

    bp_dma_word_master_state_e state_q, state_d;

    logic [dma_addr_width_p-1:0] addr_q;
    logic [dma_data_width_p-1:0] data_q;
    logic                        write_q;
    logic [dma_data_width_p-1:0] line_q [dma_burst_len_p];

    logic [cnt_width_lp-1:0] count;
    logic [cnt_width_lp-1:0] beat_idx;
    logic                    cnt_clear;
    logic                    cnt_up;
    logic                    req_accept;
    logic                    beat_in;
    bsg_cache_dma_pkt_s      pkt;

    bsg_counter_clear_up #(
        .max_val_p (dma_burst_len_p - 1),
        .init_val_p(0)
    ) beat_counter (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .clear_i  (cnt_clear),
        .up_i     (cnt_up),
        .count_o  (count)
    );

    // A one-beat line has no index bits in the address; the word always sits in slot 0.
    assign beat_idx = (lg_burst_lp == 0) ? '0 : addr_q[word_offset_lp +: cnt_width_lp];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= e_ready;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (req_accept) begin
                write_q <= req_write_i;
            end
        end
    end

    // NOTE: request payload and line buffer have no reset; each request loads them before they are read.
    always_ff @(posedge clk_i) begin
        if (req_accept) begin
            addr_q <= req_addr_i;
            data_q <= req_data_i;
        end
        if (beat_in) begin
            line_q[count] <= (write_q && (count == beat_idx)) ? data_q : dma_data_i;
        end
    end

    always_comb begin
        state_d              = state_q;
        req_ready_and_o      = 1'b0;
        resp_v_o             = 1'b0;
        resp_data_o          = '0;
        dma_pkt_v_o          = 1'b0;
        pkt                  = '0;
        dma_data_ready_and_o = 1'b0;
        dma_data_v_o         = 1'b0;
        dma_data_o           = '0;
        req_accept           = 1'b0;
        beat_in              = 1'b0;
        cnt_up               = 1'b0;
        cnt_clear            = 1'b0;

        unique case (state_q)
            e_ready: begin
                req_ready_and_o = 1'b1;
                if (req_v_i) begin
                    req_accept = 1'b1;
                    cnt_clear  = 1'b1;
                    state_d    = e_rd_pkt;
                end
            end
            e_rd_pkt: begin
                dma_pkt_v_o        = 1'b1;
                pkt.write_not_read = 1'b0;
                pkt.mask           = '1;
                pkt.addr           = addr_q & line_mask_lp;
                if (dma_pkt_yumi_i) begin
                    state_d = e_rd_data;
                end
            end
            e_rd_data: begin
                dma_data_ready_and_o = 1'b1;
                if (dma_data_v_i) begin
                    beat_in = 1'b1;
                    cnt_up  = 1'b1;
                    if (count == last_beat_lp) begin
                        if (write_q) begin
                            cnt_clear = 1'b1;
                            state_d   = e_wr_pkt;
                        end else begin
                            state_d = e_resp;
                        end
                    end
                end
            end
            e_wr_pkt: begin
                dma_pkt_v_o        = 1'b1;
                pkt.write_not_read = 1'b1;
                pkt.mask           = '1;
                pkt.addr           = addr_q & line_mask_lp;
                if (dma_pkt_yumi_i) begin
                    state_d = e_wr_data;
                end
            end
            e_wr_data: begin
                dma_data_v_o = 1'b1;
                dma_data_o   = line_q[count];
                if (dma_data_yumi_i) begin
                    cnt_up = 1'b1;
                    if (count == last_beat_lp) begin
                        state_d = e_resp;
                    end
                end
            end
            e_resp: begin
                resp_v_o    = 1'b1;
                resp_data_o = write_q ? '0 : line_q[beat_idx];
                if (resp_ready_and_i) begin
                    state_d = e_ready;
                end
            end
            default: begin
                state_d = e_ready;
            end
        endcase
    end

    assign dma_pkt_o = pkt;

endmodule
